// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM, illegal-opcode trap enabled by MULTICYCLE_CTRL_TRAP_EN
module multicycle_ctrl #(
    parameter int STATE_W       = 4,
    parameter int ALUOP_W       = 2,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [5:0]         opcode_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               i_or_d_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [1:0]         pc_source_o,
    output logic [1:0]         ext_op_o,
    output logic               instr_done_o,
    output logic               exc_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEM_ADDR = STATE_W'(2),
        S_MEM_RD   = STATE_W'(3),
        S_MEM_WB   = STATE_W'(4),
        S_MEM_WR   = STATE_W'(5),
        S_EXEC_R   = STATE_W'(6),
        S_R_WB     = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_JUMP     = STATE_W'(9),
        S_ORI_EX   = STATE_W'(10),
        S_ORI_WB   = STATE_W'(11),
        S_TRAP     = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    state_t     state;
    state_t     next_state;
    logic       ready;
    logic [1:0] alu_op;

    // Without the handshake the memory is assumed to finish every access in one cycle
    assign ready   = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
    assign state_o = state;

    // State register; reset aborts any instruction and restarts at FETCH
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Per-state datapath controls and next state; strobes are suppressed while reset is low
    always_comb begin
        next_state      = S_FETCH;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 2'b00;
        mem_to_reg_o    = 2'b00;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op          = 2'b00;
        pc_source_o     = 2'b00;
        ext_op_o        = 2'b00;
        instr_done_o    = 1'b0;
        exc_o           = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = ready;
                pc_write_o  = ready;
                next_state  = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                ext_op_o    = 2'b01;
                case (opcode_i)
                    OP_R:         next_state = S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J, OP_JAL: next_state = S_JUMP;
                    OP_ORI:       next_state = S_ORI_EX;
                    default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        next_state   = S_TRAP;
`else
                        next_state   = S_FETCH;
                        instr_done_o = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                ext_op_o    = 2'b01;
                if (opcode_i == OP_LW) begin
                    next_state = S_MEM_RD;
                end else if (opcode_i == OP_SW) begin
                    next_state = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                next_state = ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'b01;
                mem_to_reg_o = 2'b01;
                instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = ready;
                next_state   = ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op      = 2'b10;
                next_state  = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op          = 2'b01;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                instr_done_o    = 1'b1;
            end
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = 2'b10;
                instr_done_o = 1'b1;
                if (opcode_i == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'b10;
                    mem_to_reg_o = 2'b10;
                end
            end
            S_ORI_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op      = 2'b11;
                next_state  = S_ORI_WB;
            end
            S_ORI_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'b01;
                instr_done_o = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: begin
                exc_o        = 1'b1;
                pc_write_o   = 1'b1;
                pc_source_o  = 2'b11;
                instr_done_o = 1'b1;
            end
`endif
            default: begin
                next_state = S_FETCH;
            end
        endcase
        if (!rst_n_i) begin
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            i_or_d_o        = 1'b0;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
            ir_write_o      = 1'b0;
            reg_dst_o       = 2'b00;
            mem_to_reg_o    = 2'b00;
            reg_write_o     = 1'b0;
            pc_source_o     = 2'b00;
            ext_op_o        = 2'b00;
            instr_done_o    = 1'b0;
            exc_o           = 1'b0;
        end
        alu_op_o      = '0;
        alu_op_o[1:0] = alu_op;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, ext_op;
    logic       reg_write, alu_src_a, instr_done, exc;
    logic [3:0] state;

    multicycle_ctrl #(.STATE_W(4), .ALUOP_W(2), .MEM_HANDSHAKE(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .mem_ready_i(ready),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .i_or_d_o(i_or_d),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .pc_source_o(pc_source), .ext_op_o(ext_op), .instr_done_o(instr_done),
        .exc_o(exc), .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic       pcw, pcwc, iod, mr, mw, irw;
        logic [1:0] rdst, m2r;
        logic       rw, asa;
        logic [1:0] asb, aop, psrc, ext;
        logic       done, exc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    function automatic logic [25:0] pack(input exp_t e);
        return {e.st, e.pcw, e.pcwc, e.iod, e.mr, e.mw, e.irw, e.rdst, e.m2r,
                e.rw, e.asa, e.asb, e.aop, e.psrc, e.ext, e.done, e.exc};
    endfunction

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e.name = ""; e.st = st;
        e.pcw = 0; e.pcwc = 0; e.iod = 0; e.mr = 0; e.mw = 0; e.irw = 0;
        e.rdst = 0; e.m2r = 0; e.rw = 0; e.asa = 0;
        e.asb = 0; e.aop = 0; e.psrc = 0; e.ext = 0; e.done = 0; e.exc = 0;
        return e;
    endfunction

    // Hand transcription of the per-state control table
    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = blank(4'd0);
        e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction
    function automatic exp_t e_decode(input logic dn);
        exp_t e = blank(4'd1);
        e.asb = 2'b11; e.ext = 2'b01; e.done = dn;
        return e;
    endfunction
    function automatic exp_t e_mem_addr();
        exp_t e = blank(4'd2);
        e.asa = 1; e.asb = 2'b10; e.ext = 2'b01;
        return e;
    endfunction
    function automatic exp_t e_mem_rd();
        exp_t e = blank(4'd3);
        e.mr = 1; e.iod = 1;
        return e;
    endfunction
    function automatic exp_t e_mem_wb();
        exp_t e = blank(4'd4);
        e.rw = 1; e.rdst = 2'b01; e.m2r = 2'b01; e.done = 1;
        return e;
    endfunction
    function automatic exp_t e_mem_wr(input logic rdy);
        exp_t e = blank(4'd5);
        e.mw = 1; e.iod = 1; e.done = rdy;
        return e;
    endfunction
    function automatic exp_t e_exec_r();
        exp_t e = blank(4'd6);
        e.asa = 1; e.aop = 2'b10;
        return e;
    endfunction
    function automatic exp_t e_r_wb();
        exp_t e = blank(4'd7);
        e.rw = 1; e.done = 1;
        return e;
    endfunction
    function automatic exp_t e_branch();
        exp_t e = blank(4'd8);
        e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01; e.done = 1;
        return e;
    endfunction
    function automatic exp_t e_jump(input logic link);
        exp_t e = blank(4'd9);
        e.pcw = 1; e.psrc = 2'b10; e.done = 1;
        if (link) begin
            e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10;
        end
        return e;
    endfunction
    function automatic exp_t e_ori_ex();
        exp_t e = blank(4'd10);
        e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; e.ext = 2'b00;
        return e;
    endfunction
    function automatic exp_t e_ori_wb();
        exp_t e = blank(4'd11);
        e.rw = 1; e.rdst = 2'b01; e.done = 1;
        return e;
    endfunction
    function automatic exp_t e_trap();
        exp_t e = blank(4'd12);
        e.exc = 1; e.pcw = 1; e.psrc = 2'b11; e.done = 1;
        return e;
    endfunction

    // Drive one cycle of inputs just after the edge and queue what that cycle must show
    task automatic step(input string nm, input logic rstn, input logic [5:0] op,
                        input logic rdy, input exp_t e);
        @(posedge clk);
        #1;
        rst_n  = rstn;
        opcode = op;
        ready  = rdy;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation is checked per cycle at the falling edge
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (rst_n && instr_done) done_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = blank(state);
            a.pcw = pc_write; a.pcwc = pc_write_cond; a.iod = i_or_d; a.mr = mem_read;
            a.mw = mem_write; a.irw = ir_write; a.rdst = reg_dst; a.m2r = mem_to_reg;
            a.rw = reg_write; a.asa = alu_src_a; a.asb = alu_src_b; a.aop = alu_op;
            a.psrc = pc_source; a.ext = ext_op; a.done = instr_done; a.exc = exc;
            tests++;
            if (pack(a) !== pack(e)) begin
                fails++;
                $display("FAIL %s: got %h expected %h (state,pcw,pcwc,iod,mr,mw,irw,rdst,m2r,rw,asa,asb,aop,psrc,ext,done,exc)",
                         e.name, pack(a), pack(e));
            end
        end
    end

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] ILL = 6'b111111;

    initial begin
        rst_n  = 1'b0;
        opcode = 6'd0;
        ready  = 1'b1;

        step("reset_held", 0, RT, 1, blank(4'd0));
        exp_q[$].asb = 2'b01;
        step("reset_release_fetch", 1, LW, 1, e_fetch(1));

        step("lw_decode",   1, LW, 1, e_decode(0));
        step("lw_mem_addr", 1, LW, 1, e_mem_addr());
        step("lw_mem_rd",   1, LW, 1, e_mem_rd());
        step("lw_mem_wb",   1, LW, 1, e_mem_wb());

        step("sw_fetch",    1, SW, 1, e_fetch(1));
        step("sw_decode",   1, SW, 1, e_decode(0));
        step("sw_mem_addr", 1, SW, 1, e_mem_addr());
        step("sw_wait1",    1, SW, 0, e_mem_wr(0));
        step("sw_wait2",    1, SW, 0, e_mem_wr(0));
        step("sw_wait3",    1, SW, 0, e_mem_wr(0));
        step("sw_mem_wr",   1, SW, 1, e_mem_wr(1));

        step("beq_fetch",   1, BEQ, 1, e_fetch(1));
        step("beq_decode_ready_ignored", 1, BEQ, 0, e_decode(0));
        step("beq_branch",  1, BEQ, 0, e_branch());

        step("jal_fetch",   1, JAL, 1, e_fetch(1));
        step("jal_decode",  1, JAL, 1, e_decode(0));
        step("jal_jump",    1, JAL, 1, e_jump(1));

        step("j_fetch",     1, JMP, 1, e_fetch(1));
        step("j_decode",    1, JMP, 1, e_decode(0));
        step("j_jump",      1, JMP, 1, e_jump(0));

        step("r_fetch_wait1", 1, RT, 0, e_fetch(0));
        step("r_fetch_wait2", 1, RT, 0, e_fetch(0));
        step("r_fetch",     1, RT, 1, e_fetch(1));
        step("r_decode",    1, RT, 1, e_decode(0));
        step("r_exec",      1, RT, 1, e_exec_r());
        step("r_wb",        1, RT, 1, e_r_wb());

        step("ill_fetch",   1, ILL, 1, e_fetch(1));
`ifdef MULTICYCLE_CTRL_TRAP_EN
        step("ill_decode",  1, ILL, 1, e_decode(0));
        step("ill_trap",    1, ILL, 1, e_trap());
`else
        step("ill_decode_nop", 1, ILL, 1, e_decode(1));
`endif

        step("lw2_fetch_after_ill", 1, LW, 1, e_fetch(1));
        step("lw2_decode",  1, LW, 1, e_decode(0));
        step("lw2_mem_addr", 1, LW, 1, e_mem_addr());
        step("lw2_mem_rd_wait", 1, LW, 0, e_mem_rd());
        step("lw2_reset_in_wait", 0, LW, 0, blank(4'd3));
        step("after_reset_fetch", 1, ORI, 1, e_fetch(1));

        step("ori_decode",  1, ORI, 1, e_decode(0));
        step("ori_exec",    1, ORI, 1, e_ori_ex());
        step("ori_wb",      1, ORI, 1, e_ori_wb());
        step("idle_fetch",  1, ORI, 0, e_fetch(0));

        @(posedge clk);
        @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        tests++;
        if (done_cnt != 8) begin
            fails++;
            $display("FAIL done_pulses: got %0d expected 8", done_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
